// File: rtl/button_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_pkg
//  Description : Shared types and parameter-derived helper constants for the
//                button event arbiter and its sample tick generator.
//                evt_t    - event record {id, rising} as seen by consumers.
//                tick_max - last value of the sample tick counter.
//                tick_w   - width of the sample tick counter.
//                stab_w   - width of a per-channel stability counter.
//                id_w     - width of a channel index.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_event_pkg;

    // Widest channel index supported by the event record.
    localparam int c_ID_W_MAX = 8;

    // rising = 1 for a press (0->1), 0 for a release (1->0).
    typedef struct packed {
        logic [c_ID_W_MAX-1:0] id;
        logic                  rising;
    } evt_t;

    function automatic int tick_max(input int clk_rate, input int sample_rate);
        return (clk_rate / sample_rate) - 1;
    endfunction

    function automatic int tick_w(input int clk_rate, input int sample_rate);
        return $clog2(tick_max(clk_rate, sample_rate) + 1);
    endfunction

    function automatic int stab_w(input int stable_samples);
        return $clog2(stable_samples);
    endfunction

    function automatic int id_w(input int num_buttons);
        return $clog2(num_buttons);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_arbiter_sample_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Free-running divider producing a one-cycle tick at
//                SampleRate from a ClkRate clock. The counter runs
//                0..TickMax and tick_o is high while it sits at TickMax.
//  Ports       : clk_i  - clock
//                rst_i  - synchronous active-high reset
//                tick_o - one-cycle sample strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen
    import button_event_pkg::*;
#(
    parameter int ClkRate    = 100_000_000,
    parameter int SampleRate = 1_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int                  c_TICK_MAX  = tick_max(ClkRate, SampleRate);
    localparam int                  c_TICK_W    = tick_w(ClkRate, SampleRate);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(c_TICK_MAX);

    logic [c_TICK_W-1:0] r_cnt;
    logic                w_wrap;

    assign w_wrap = (r_cnt == c_TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = w_wrap;

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_arbiter
//  Description : Debounces NumButtons raw switches and serialises their
//                press/release events onto one valid/ready stream through a
//                round-robin arbiter feeding a single output register.
//  Ports       : clk_i       - clock
//                rst_i       - synchronous active-high reset
//                sw_i        - raw asynchronous switch inputs
//                level_o     - debounced level per channel
//                evt_valid_o - event available
//                evt_ready_i - consumer accepts event
//                evt_id_o    - channel index of event
//                evt_edge_o  - 1 = press, 0 = release
//                overflow_o  - sticky: an unconsumed pending event was lost
//                clear_ovf_i - clears overflow_o
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter int NumButtons    = 4,
    parameter int ClkRate       = 100_000_000,
    parameter int SampleRate    = 1_000,
    parameter int StableSamples = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumButtons-1:0]         sw_i,
    output logic [NumButtons-1:0]         level_o,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [$clog2(NumButtons)-1:0] evt_id_o,
    output logic                          evt_edge_o,
    output logic                          overflow_o,
    input  logic                          clear_ovf_i
);

    localparam int                  c_ID_W      = id_w(NumButtons);
    localparam int                  c_STAB_W    = stab_w(StableSamples);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(StableSamples - 1);
    localparam logic [c_ID_W-1:0]   c_ID_LAST   = c_ID_W'(NumButtons - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser; r_sync2 is the only copy the debouncer sees.
    // ------------------------------------------------------------------
    logic [NumButtons-1:0] r_sync1;
    logic [NumButtons-1:0] r_sync2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
        end
    end

    logic w_tick;

    sample_tick_gen #(
        .ClkRate    (ClkRate),
        .SampleRate (SampleRate)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (w_tick)
    );

    // ------------------------------------------------------------------
    // Per-channel debounce and one-deep pending slot
    // ------------------------------------------------------------------
    logic [NumButtons-1:0] w_level;
    logic [NumButtons-1:0] w_pend;
    logic [NumButtons-1:0] w_pend_edge;
    logic [NumButtons-1:0] w_overwrite;
    logic [NumButtons-1:0] w_grant_vec;

    for (genvar gi = 0; gi < NumButtons; gi++) begin : g_chan
        logic                r_level;
        logic [c_STAB_W-1:0] r_stab;
        logic                r_pend;
        logic                r_pend_edge;
        logic                w_accept;

        assign w_accept = w_tick && (r_sync2[gi] != r_level) && (r_stab == c_STAB_LAST);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_level     <= 1'b0;
                r_stab      <= '0;
                r_pend      <= 1'b0;
                r_pend_edge <= 1'b0;
            end else begin
                if (w_tick) begin
                    if (r_sync2[gi] == r_level) begin
                        r_stab <= '0;
                    end else if (r_stab == c_STAB_LAST) begin
                        r_level <= r_sync2[gi];
                        r_stab  <= '0;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end
                // A fresh acceptance outranks a same-cycle grant: the grant
                // has already taken the old edge, the new one stays pending.
                if (w_accept) begin
                    r_pend      <= 1'b1;
                    r_pend_edge <= r_sync2[gi];
                end else if (w_grant_vec[gi]) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign w_level[gi]     = r_level;
        assign w_pend[gi]      = r_pend;
        assign w_pend_edge[gi] = r_pend_edge;
        assign w_overwrite[gi] = w_accept && r_pend && !w_grant_vec[gi];
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter into the single output register
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [c_ID_W-1:0] r_id;
    logic              r_edge;
    logic [c_ID_W-1:0] r_ptr;
    logic              r_ovf;

    logic              w_load;
    logic              w_found;
    logic [c_ID_W-1:0] w_grant_idx;
    logic              w_grant_edge;
    logic [c_ID_W-1:0] w_next_ptr;
    logic [c_ID_W-1:0] w_try_idx;
    int                w_try;

    // The register can take a new event when empty or emptying this cycle.
    assign w_load = !r_valid || evt_ready_i;

    always_comb begin
        w_found      = 1'b0;
        w_grant_idx  = '0;
        w_grant_edge = 1'b0;
        w_grant_vec  = '0;
        w_try        = 0;
        w_try_idx    = '0;
        for (int k = 0; k < NumButtons; k++) begin
            w_try = int'(r_ptr) + k;
            if (w_try >= NumButtons) begin
                w_try = w_try - NumButtons;
            end
            w_try_idx = c_ID_W'(w_try);
            if (w_load && !w_found && w_pend[w_try_idx]) begin
                w_found                = 1'b1;
                w_grant_idx            = w_try_idx;
                w_grant_edge           = w_pend_edge[w_try_idx];
                w_grant_vec[w_try_idx] = 1'b1;
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == c_ID_LAST) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_edge  <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_id    <= w_grant_idx;
                r_edge  <= w_grant_edge;
                r_ptr   <= w_next_ptr;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Set has priority over clear so a loss in the clearing cycle survives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (|w_overwrite) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign level_o     = w_level;
    assign evt_valid_o = r_valid;
    assign evt_id_o    = r_id;
    assign evt_edge_o  = r_edge;
    assign overflow_o  = r_ovf;

endmodule
`default_nettype wire
